mult_seq_ctrl: RTL and testbench

//  Sequential shift-and-add multiplier controller. One shared 2*WIDTH-bit ripple adder
//  (adder_8bit at WIDTH=4) is reused over WIDTH cycles instead of the three-adder

---
 rtl/mult_seq_ctrl.sv | 104 ++++++++++
 tb/tb_mult_seq_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mult_seq_ctrl.sv
// Sequential shift-and-add multiplier controller.
// A single 2*WIDTH-bit adder accumulates one partial product per cycle over
// WIDTH cycles. Start/busy/done handshake. The product is registered and held
// until the next operation completes.
module mult_seq_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [WIDTH-1:0] aReg_q, aReg_d;
  logic [WIDTH-1:0] bReg_q, bReg_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    product_q, product_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [PW-1:0]    addend;
  logic [PW-1:0]    sum;
  logic             carry;

  // Shared adder: add the shifted multiplicand when the current multiplier bit is set.
  always_comb begin
    addend = bReg_q[cnt_q] ? (PW'(aReg_q) << cnt_q) : '0;
    {carry, sum} = {1'b0, acc_q} + {1'b0, addend};
  end

  // Next-state and datapath update; a new operation is latched whenever start meets a non-busy state.
  always_comb begin
    state_d   = state_q;
    aReg_d    = aReg_q;
    bReg_d    = bReg_q;
    acc_d     = acc_q;
    product_d = product_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          aReg_d  = a;
          bReg_d  = b;
          acc_d   = '0;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        acc_d = sum;
        if (cnt_q == CW'(WIDTH - 1)) begin
          product_d = sum;
          cnt_d     = '0;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset that also aborts a running sequence.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      aReg_q    <= '0;
      bReg_q    <= '0;
      acc_q     <= '0;
      product_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      aReg_q    <= aReg_d;
      bReg_q    <= bReg_d;
      acc_q     <= acc_d;
      product_q <= product_d;
      cnt_q     <= cnt_d;
    end
  end

  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign product = product_q;

  // The product of two WIDTH-bit operands always fits in 2*WIDTH bits, so the adder never carries out.
  carryNeverSet: assert property (@(posedge clk) disable iff (reset) (state_q == RUN) |-> !carry);

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench for mult_seq_ctrl: directed scenarios plus randomized
// traffic, all compared cycle by cycle against a behavioural model.
module tb_mult_seq_ctrl;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  int checks = 0;
  int errors = 0;

  // Behavioural model: an accepted operation occupies W busy cycles, then one done cycle.
  int             mBusyLeft = 0;
  bit             mDone     = 1'b0;
  logic [2*W-1:0] mProduct  = '0;
  logic [2*W-1:0] mPending  = '0;
  bit             mAccept;
  bit             checkEn   = 1'b0;

  mult_seq_ctrl #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance the model on every edge, then compare the DUT just after the edge.
  always @(posedge clk) begin
    if (reset) begin
      mBusyLeft = 0;
      mDone     = 1'b0;
      mProduct  = '0;
    end else begin
      mAccept = start && (mBusyLeft == 0);
      mDone   = (mBusyLeft == 1);
      if (mBusyLeft == 1) mProduct = mPending;
      if (mBusyLeft > 0) mBusyLeft--;
      if (mAccept) begin
        mPending  = (2*W)'(int'(a) * int'(b));
        mBusyLeft = W;
      end
    end
    #1;
    if (checkEn) begin
      checkOutput("cycBusy", {31'd0, busy}, {31'd0, (mBusyLeft > 0)});
      checkOutput("cycDone", {31'd0, done}, {31'd0, mDone});
      checkOutput("cycProduct", {24'd0, product}, {24'd0, mProduct});
    end
  end

  // Pulse start for one cycle with operands x,y, scramble the operand inputs afterwards,
  // and wait (bounded) for done. Called and returns on a negedge.
  task automatic applyStimulus(input logic [W-1:0] x, input logic [W-1:0] y,
                               input logic [2*W-1:0] expP, input string tag,
                               output int latency, output int busyCycles);
    a = x;
    b = y;
    start = 1'b1;
    latency = 0;
    busyCycles = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      start = 1'b0;
      a = ~x;
      b = ~y;
      if (busy) busyCycles++;
      if (done) begin
        latency = n;
        break;
      end
    end
    if (latency == 0) checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
    else checkOutput({tag, "_prod"}, {24'd0, product}, {24'd0, expP});
  endtask

  int lat, bc, doneCount, first, second;

  initial begin
    reset = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(negedge clk);
    checkEn = 1'b1;
    reset = 1'b0;

    // Reset then idle.
    repeat (3) @(negedge clk);
    checkOutput("rstBusy", {31'd0, busy}, 32'd0);
    checkOutput("rstDone", {31'd0, done}, 32'd0);
    checkOutput("rstProduct", {24'd0, product}, 32'h00);

    // Largest operands: latency and busy length.
    applyStimulus(4'hF, 4'hF, 8'hE1, "maxOp", lat, bc);
    checkOutput("maxOpLatency", lat, 5);
    checkOutput("maxOpBusyCycles", bc, 4);
    repeat (2) @(negedge clk);

    // Operands change right after acceptance.
    applyStimulus(4'h7, 4'h3, 8'h15, "latched", lat, bc);
    repeat (2) @(negedge clk);

    // Start pulsed during RUN is ignored.
    a = 4'h2; b = 4'h3; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); start = 1'b1; a = 4'h5;
    @(negedge clk); start = 1'b0;
    doneCount = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (done) begin
        doneCount++;
        checkOutput("ignoreProd", {24'd0, product}, 32'd6);
      end
    end
    checkOutput("ignoreDoneCount", doneCount, 1);

    // Start held high: back-to-back acceptance in DONE.
    a = 4'h5; b = 4'h6; start = 1'b1;
    first = 0; second = 0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (n == 1) begin
        a = 4'h3;
        b = 4'h4;
      end
      if (done) begin
        if (first == 0) begin
          first = n;
          checkOutput("heldProd1", {24'd0, product}, 32'd30);
        end else begin
          second = n;
          checkOutput("heldProd2", {24'd0, product}, 32'd12);
          break;
        end
      end
    end
    start = 1'b0;
    if (second == 0) checkOutput("heldTimeout", 32'd0, 32'd1);
    else checkOutput("heldGap", second - first, 5);
    repeat (3) @(negedge clk);

    // Reset on the second RUN cycle aborts the operation.
    a = 4'h9; b = 4'h9; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    checkOutput("abortBusy", {31'd0, busy}, 32'd0);
    checkOutput("abortDone", {31'd0, done}, 32'd0);
    checkOutput("abortProduct", {24'd0, product}, 32'd0);
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      checkOutput("abortNoDone", {31'd0, done}, 32'd0);
    end

    // Exhaustive operand pairs, issued back to back.
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        applyStimulus(W'(i), W'(j), (2*W)'(i * j), "exhaust", lat, bc);
      end
    end
    repeat (2) @(negedge clk);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      a = W'($urandom);
      b = W'($urandom);
      reset = ($urandom_range(0, 99) == 0);
    end
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    repeat (8) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
